// File: rtl/rvc_fetch_aligner.sv
// rvc_fetch_aligner
//   Splits 32-bit fetch words into 16-bit parcels and reassembles them into
//   whole instructions for decode. A compressed instruction is one parcel.
//   A 32-bit instruction is two parcels and may straddle a fetch word. The
//   block also handles redirects to halfword-aligned targets.
//
//   Build option: define RV32C_EN to enable compressed support. Without it,
//   every fetch word is one 32-bit instruction held in a single slot.
//
// Ports
//   iCLK          clock, all state updates on the rising edge
//   iRST_N        asynchronous active-low reset
//   iFETCH_VALID  fetch word available
//   oFETCH_READY  aligner accepts the fetch word this cycle
//   iFETCH_DATA   fetch word, [15:0] is the lower-address halfword
//   iFLUSH        redirect: discard all buffered parcels
//   iFLUSH_PC     redirect target (bit 0 ignored)
//   oINSTR_VALID  complete instruction at the head of the buffer
//   iINSTR_READY  decoder consumes the instruction
//   oINSTR        instruction, compressed ones are {16'h0, parcel}
//   oINSTR_PC     address of oINSTR
//   oINSTR_IS_C   oINSTR is a 16-bit instruction
module rvc_fetch_aligner (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iFETCH_VALID,
  output logic        oFETCH_READY,
  input  logic [31:0] iFETCH_DATA,
  input  logic        iFLUSH,
  input  logic [31:0] iFLUSH_PC,
  output logic        oINSTR_VALID,
  input  logic        iINSTR_READY,
  output logic [31:0] oINSTR,
  output logic [31:0] oINSTR_PC,
  output logic        oINSTR_IS_C
);

`ifdef RV32C_EN

  logic [15:0] hw [3];
  logic [1:0]  cnt;
  logic [31:0] pc;
  logic        drop;

  logic        headIsC;
  logic        headComplete;
  logic        instrValid;
  logic        fetchReady;
  logic        consume;
  logic        accept;
  logic [1:0]  shiftAmt;
  logic [1:0]  cntShift;
  logic [15:0] nextHw [3];
  logic [1:0]  nextCnt;
  logic [31:0] nextPc;
  logic        unusedFlushBit;

  assign unusedFlushBit = iFLUSH_PC[0];

  // Head decode, handshakes, and the next buffer contents. The buffer is
  // shifted by the consumed instruction first, then the accepted word's
  // parcels are appended behind whatever remains. Accept only happens with
  // CNT <= 1, so the buffer never needs more than three slots.
  always_comb begin
    headIsC      = (hw[0][1:0] != 2'b11);
    headComplete = headIsC ? (cnt != 2'd0) : (cnt >= 2'd2);
    instrValid   = headComplete && !iFLUSH;
    fetchReady   = (cnt <= 2'd1) && !iFLUSH;
    consume      = instrValid && iINSTR_READY;
    accept       = iFETCH_VALID && fetchReady;
    shiftAmt     = consume ? (headIsC ? 2'd1 : 2'd2) : 2'd0;
    cntShift     = cnt - shiftAmt;

    nextHw[0] = hw[0];
    nextHw[1] = hw[1];
    nextHw[2] = hw[2];
    case (shiftAmt)
      2'd1: begin
        nextHw[0] = hw[1];
        nextHw[1] = hw[2];
        nextHw[2] = 16'h0;
      end
      2'd2: begin
        nextHw[0] = hw[2];
        nextHw[1] = 16'h0;
        nextHw[2] = 16'h0;
      end
      default: ;
    endcase

    nextCnt = cntShift;
    if (accept) begin
      for (int i = 0; i < 3; i++) begin
        if (drop) begin
          if (i == int'(cntShift)) nextHw[i] = iFETCH_DATA[31:16];
        end else begin
          if (i == int'(cntShift))     nextHw[i] = iFETCH_DATA[15:0];
          if (i == int'(cntShift) + 1) nextHw[i] = iFETCH_DATA[31:16];
        end
      end
      nextCnt = drop ? cntShift + 2'd1 : cntShift + 2'd2;
    end

    nextPc = pc;
    if (consume) nextPc = pc + (headIsC ? 32'd2 : 32'd4);
  end

  // State register. A flush wins over everything and, when the target is the
  // upper halfword of a word, arms DROP so the first word's lower parcel is
  // discarded.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int i = 0; i < 3; i++) hw[i] <= 16'h0;
      cnt  <= 2'd0;
      pc   <= 32'h0;
      drop <= 1'b0;
    end else if (iFLUSH) begin
      cnt  <= 2'd0;
      pc   <= {iFLUSH_PC[31:1], 1'b0};
      drop <= iFLUSH_PC[1];
    end else begin
      for (int i = 0; i < 3; i++) hw[i] <= nextHw[i];
      cnt <= nextCnt;
      pc  <= nextPc;
      if (accept) drop <= 1'b0;
    end
  end

  assign oFETCH_READY = fetchReady;
  assign oINSTR_VALID = instrValid;
  assign oINSTR       = instrValid ? (headIsC ? {16'h0, hw[0]} : {hw[1], hw[0]}) : 32'h0;
  assign oINSTR_PC    = instrValid ? pc : 32'h0;
  assign oINSTR_IS_C  = instrValid && headIsC;

`else

  logic [31:0] slot;
  logic        slotValid;
  logic [31:0] pc;

  logic        instrValid;
  logic        consume;
  logic        fetchReady;
  logic        accept;
  logic [1:0]  unusedFlushBits;

  assign unusedFlushBits = iFLUSH_PC[1:0];

  // A single word slot. It can be refilled in the same cycle it is consumed,
  // which keeps one instruction per cycle with a steady fetch stream.
  always_comb begin
    instrValid = slotValid && !iFLUSH;
    consume    = instrValid && iINSTR_READY;
    fetchReady = (!slotValid || consume) && !iFLUSH;
    accept     = iFETCH_VALID && fetchReady;
  end

  // State register. Redirect targets are forced word-aligned here.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      slot      <= 32'h0;
      slotValid <= 1'b0;
      pc        <= 32'h0;
    end else if (iFLUSH) begin
      slotValid <= 1'b0;
      pc        <= {iFLUSH_PC[31:2], 2'b00};
    end else begin
      if (consume) pc <= pc + 32'd4;
      if (accept) begin
        slot      <= iFETCH_DATA;
        slotValid <= 1'b1;
      end else if (consume) begin
        slotValid <= 1'b0;
      end
    end
  end

  assign oFETCH_READY = fetchReady;
  assign oINSTR_VALID = instrValid;
  assign oINSTR       = instrValid ? slot : 32'h0;
  assign oINSTR_PC    = instrValid ? pc : 32'h0;
  assign oINSTR_IS_C  = 1'b0;

`endif

endmodule

// File: tb/tb_rvc_fetch_aligner.sv
// tb_rvc_fetch_aligner
//   Directed bench for rvc_fetch_aligner. Inputs are driven 1 time unit after
//   the rising edge and outputs are checked before the next edge. The
//   sequence follows whichever build of the aligner is compiled (RV32C_EN).
module tb_rvc_fetch_aligner;

  logic        iCLK;
  logic        iRST_N;
  logic        iFETCH_VALID;
  logic        oFETCH_READY;
  logic [31:0] iFETCH_DATA;
  logic        iFLUSH;
  logic [31:0] iFLUSH_PC;
  logic        oINSTR_VALID;
  logic        iINSTR_READY;
  logic [31:0] oINSTR;
  logic [31:0] oINSTR_PC;
  logic        oINSTR_IS_C;

  int total = 0;
  int bad   = 0;

  rvc_fetch_aligner dut (
    .iCLK         (iCLK),
    .iRST_N       (iRST_N),
    .iFETCH_VALID (iFETCH_VALID),
    .oFETCH_READY (oFETCH_READY),
    .iFETCH_DATA  (iFETCH_DATA),
    .iFLUSH       (iFLUSH),
    .iFLUSH_PC    (iFLUSH_PC),
    .oINSTR_VALID (oINSTR_VALID),
    .iINSTR_READY (iINSTR_READY),
    .oINSTR       (oINSTR),
    .oINSTR_PC    (oINSTR_PC),
    .oINSTR_IS_C  (oINSTR_IS_C)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic applyStimulus(input logic fv, input logic [31:0] fdata,
                               input logic ir, input logic fl,
                               input logic [31:0] flpc);
    iFETCH_VALID = fv;
    iFETCH_DATA  = fdata;
    iINSTR_READY = ir;
    iFLUSH       = fl;
    iFLUSH_PC    = flpc;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: got %08h, want %08h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic checkInstr(input string tag, input logic [31:0] instr,
                            input logic [31:0] pc, input logic isC);
    checkOutput({tag, ".valid"}, {31'h0, oINSTR_VALID}, 32'd1);
    checkOutput({tag, ".instr"}, oINSTR, instr);
    checkOutput({tag, ".pc"}, oINSTR_PC, pc);
    checkOutput({tag, ".isC"}, {31'h0, oINSTR_IS_C}, {31'h0, isC});
  endtask

  // Directed sequence.
  initial begin
    iRST_N = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #10;
    checkOutput("rst.valid", {31'h0, oINSTR_VALID}, 32'd0);
    checkOutput("rst.instr", oINSTR, 32'h0);
    checkOutput("rst.pc", oINSTR_PC, 32'h0);
    checkOutput("rst.isC", {31'h0, oINSTR_IS_C}, 32'd0);
    iRST_N = 1'b1;
    #1;
    checkOutput("rst.fetchReady", {31'h0, oFETCH_READY}, 32'd1);

`ifdef RV32C_EN
    $display("[TB] compressed build");
    applyStimulus(1'b1, 32'h00130093, 1'b1, 1'b0, 32'h0);
    checkOutput("s1.valid", {31'h0, oINSTR_VALID}, 32'd0);
    checkOutput("s1.fetchReady", {31'h0, oFETCH_READY}, 32'd1);
    tick();
    applyStimulus(1'b1, 32'h00208113, 1'b1, 1'b0, 32'h0);
    checkInstr("s2", 32'h00130093, 32'h0, 1'b0);
    checkOutput("s2.fetchReady", {31'h0, oFETCH_READY}, 32'd0);
    tick();
    checkOutput("s3.valid", {31'h0, oINSTR_VALID}, 32'd0);
    checkOutput("s3.fetchReady", {31'h0, oFETCH_READY}, 32'd1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkInstr("s4", 32'h00208113, 32'h4, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h40014081, 1'b1, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkInstr("c0", 32'h00004081, 32'h8, 1'b1);
    checkOutput("c0.fetchReady", {31'h0, oFETCH_READY}, 32'd0);
    tick();
    applyStimulus(1'b1, 32'h00934501, 1'b1, 1'b0, 32'h0);
    checkInstr("c1", 32'h00004001, 32'hA, 1'b1);
    checkOutput("c1.fetchReady", {31'h0, oFETCH_READY}, 32'd1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkInstr("cli", 32'h00004501, 32'hC, 1'b1);
    tick();
    applyStimulus(1'b1, 32'h12340013, 1'b1, 1'b0, 32'h0);
    checkOutput("strad.wait", {31'h0, oINSTR_VALID}, 32'd0);
    checkOutput("strad.fetchReady", {31'h0, oFETCH_READY}, 32'd1);
    tick();
    applyStimulus(1'b1, 32'h55554444, 1'b0, 1'b0, 32'h0);
    checkInstr("strad", 32'h00130093, 32'hE, 1'b0);
    checkOutput("strad.full", {31'h0, oFETCH_READY}, 32'd0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkInstr("strad.hold", 32'h00130093, 32'hE, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h55554444, 1'b0, 1'b0, 32'h0);
    checkInstr("tail", 32'h00001234, 32'h12, 1'b1);
    checkOutput("tail.fetchReady", {31'h0, oFETCH_READY}, 32'd1);
    tick();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 32'h77776666, 1'b0, 1'b0, 32'h0);
      checkInstr("bp", 32'h00001234, 32'h12, 1'b1);
      checkOutput("bp.fetchReady", {31'h0, oFETCH_READY}, 32'd0);
      tick();
    end
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkInstr("rel0", 32'h00001234, 32'h12, 1'b1);
    tick();
    checkInstr("rel1", 32'h00004444, 32'h14, 1'b1);
    tick();
    applyStimulus(1'b1, 32'h99998888, 1'b0, 1'b0, 32'h0);
    checkInstr("rel2", 32'h00005555, 32'h16, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h00000102);
    checkOutput("flush.valid", {31'h0, oINSTR_VALID}, 32'd0);
    checkOutput("flush.fetchReady", {31'h0, oFETCH_READY}, 32'd0);
    checkOutput("flush.instr", oINSTR, 32'h0);
    tick();
    applyStimulus(1'b1, 32'hC1014581, 1'b1, 1'b0, 32'h0);
    checkOutput("postFlush.valid", {31'h0, oINSTR_VALID}, 32'd0);
    checkOutput("postFlush.fetchReady", {31'h0, oFETCH_READY}, 32'd1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkInstr("drop", 32'h0000C101, 32'h102, 1'b1);
    tick();
    checkOutput("drop.empty", {31'h0, oINSTR_VALID}, 32'd0);
    applyStimulus(1'b1, 32'h40014081, 1'b0, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkInstr("preRst", 32'h00004081, 32'h104, 1'b1);
`else
    $display("[TB] word-only build");
    applyStimulus(1'b1, 32'h00130093, 1'b1, 1'b0, 32'h0);
    checkOutput("s1.valid", {31'h0, oINSTR_VALID}, 32'd0);
    checkOutput("s1.fetchReady", {31'h0, oFETCH_READY}, 32'd1);
    tick();
    applyStimulus(1'b1, 32'h00208113, 1'b1, 1'b0, 32'h0);
    checkInstr("s2", 32'h00130093, 32'h0, 1'b0);
    checkOutput("s2.fetchReady", {31'h0, oFETCH_READY}, 32'd1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkInstr("s3", 32'h00208113, 32'h4, 1'b0);
    tick();
    checkOutput("s4.valid", {31'h0, oINSTR_VALID}, 32'd0);
    applyStimulus(1'b1, 32'h11111111, 1'b0, 1'b0, 32'h0);
    checkOutput("s4.fetchReady", {31'h0, oFETCH_READY}, 32'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h22222222, 1'b0, 1'b0, 32'h0);
      checkInstr("bp", 32'h11111111, 32'h8, 1'b0);
      checkOutput("bp.fetchReady", {31'h0, oFETCH_READY}, 32'd0);
      tick();
    end
    applyStimulus(1'b1, 32'h22222222, 1'b1, 1'b0, 32'h0);
    checkInstr("rel0", 32'h11111111, 32'h8, 1'b0);
    checkOutput("rel0.fetchReady", {31'h0, oFETCH_READY}, 32'd1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkInstr("rel1", 32'h22222222, 32'hC, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h00000102);
    checkOutput("flush.valid", {31'h0, oINSTR_VALID}, 32'd0);
    checkOutput("flush.fetchReady", {31'h0, oFETCH_READY}, 32'd0);
    checkOutput("flush.instr", oINSTR, 32'h0);
    tick();
    applyStimulus(1'b1, 32'hCAFEF00D, 1'b1, 1'b0, 32'h0);
    checkOutput("postFlush.valid", {31'h0, oINSTR_VALID}, 32'd0);
    checkOutput("postFlush.fetchReady", {31'h0, oFETCH_READY}, 32'd1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFFFFFE);
    tick();
    applyStimulus(1'b1, 32'h0BADBEEF, 1'b1, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b1, 32'h00000013, 1'b1, 1'b0, 32'h0);
    checkInstr("wrap0", 32'h0BADBEEF, 32'hFFFFFFFC, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkInstr("wrap1", 32'h00000013, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h00000104);
    tick();
    applyStimulus(1'b1, 32'h00500093, 1'b1, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkInstr("target", 32'h00500093, 32'h104, 1'b0);
`endif

    iRST_N = 1'b0;
    #1;
    checkOutput("midRst.valid", {31'h0, oINSTR_VALID}, 32'd0);
    checkOutput("midRst.instr", oINSTR, 32'h0);
    checkOutput("midRst.pc", oINSTR_PC, 32'h0);
    iRST_N = 1'b1;
    #1;
    checkOutput("midRst.fetchReady", {31'h0, oFETCH_READY}, 32'd1);
    checkOutput("midRst.empty", {31'h0, oINSTR_VALID}, 32'd0);
    applyStimulus(1'b1, 32'h00130093, 1'b1, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkInstr("restart", 32'h00130093, 32'h0, 1'b0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
